// File: rtl/konata_id_tracker_pkg.sv
// Shared types and constants for the konata pipeline ID tracker.
// Optional statistics counters are enabled by defining KONATA_TRACKER_STATS_EN.
package konata_id_tracker_pkg;

  localparam int unsigned KONATA_NSTG = 6;

  typedef enum logic [2:0] {
    STG_IF1 = 3'd0,
    STG_IF2 = 3'd1,
    STG_ID  = 3'd2,
    STG_RR  = 3'd3,
    STG_EXE = 3'd4,
    STG_WB  = 3'd5
  } konata_stage_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] id;
  } konata_entry_t;

endpackage

// File: rtl/konata_id_tracker_stage_reg.sv
// One tracked pipeline slot: valid/ID register with kill > hold > bubble > load priority.
module konata_stage_reg
  import konata_id_tracker_pkg::*;
#(
  parameter int unsigned ID_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            hold_i,
  input  logic            bubble_i,
  input  logic            in_valid_i,
  input  logic [ID_W-1:0] in_id_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  logic            valid_d, valid_q;
  logic [ID_W-1:0] id_d, id_q;

  // The ID field is only replaced on a real load; kills and bubbles leave it stale.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (bubble_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = in_valid_i;
      id_d    = in_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign valid_o = valid_q;
  assign id_o    = id_q;

endmodule

// File: rtl/konata_id_tracker.sv
// Tracks instruction IDs through IF1..WB for the konata trace dumper; observe-only.
// Define KONATA_TRACKER_STATS_EN to build the retired/flushed statistics counters.
module konata_id_tracker
  import konata_id_tracker_pkg::*;
#(
  parameter int unsigned ID_W  = 64,
  parameter int unsigned NSTG  = KONATA_NSTG,
  parameter int unsigned CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid_i,
  input  logic [NSTG-2:0]      stall_i,
  input  logic [NSTG-2:0]      flush_i,
  output logic [NSTG-1:0]      stage_valid_o,
  output logic [NSTG*ID_W-1:0] stage_id_o,
  output logic [ID_W-1:0]      next_id_o,
  output logic                 retire_o,
  output logic [CNT_W-1:0]     retired_cnt_o,
  output logic [CNT_W-1:0]     flushed_cnt_o
);

  localparam int unsigned WB = 32'(STG_WB);

  logic [NSTG-1:0] hold_c, kill_c, bubble_c, in_valid_c, valid_w;
  logic [ID_W-1:0] in_id_c [NSTG];
  logic [ID_W-1:0] id_w    [NSTG];
  logic            alloc_c;
  logic [ID_W-1:0] next_id_d, next_id_q;

  // An older stall/flush covers every younger stage; WB never holds or is killed.
  always_comb begin
    hold_c = '0;
    kill_c = '0;
    for (int unsigned k = 0; k < NSTG - 1; k++) begin
      hold_c[k] = |(stall_i >> k);
      kill_c[k] = |(flush_i >> k);
    end
  end

  always_comb begin
    in_valid_c[0] = fetch_valid_i;
    in_id_c[0]    = next_id_q;
    bubble_c[0]   = ~fetch_valid_i;
    for (int unsigned k = 1; k < NSTG; k++) begin
      in_valid_c[k] = valid_w[k-1];
      in_id_c[k]    = id_w[k-1];
      bubble_c[k]   = hold_c[k-1] | kill_c[k-1];
    end
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    konata_stage_reg #(.ID_W(ID_W)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .kill_i    (kill_c[g]),
      .hold_i    (hold_c[g]),
      .bubble_i  (bubble_c[g]),
      .in_valid_i(in_valid_c[g]),
      .in_id_i   (in_id_c[g]),
      .valid_o   (valid_w[g]),
      .id_o      (id_w[g])
    );
    assign stage_id_o[g*ID_W +: ID_W] = id_w[g];
  end

  // Allocation counter wraps silently.
  always_comb begin
    alloc_c   = fetch_valid_i & ~hold_c[0] & ~kill_c[0];
    next_id_d = next_id_q;
    if (alloc_c) begin
      next_id_d = next_id_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_id_q <= '0;
    end else begin
      next_id_q <= next_id_d;
    end
  end

  assign stage_valid_o = valid_w;
  assign next_id_o     = next_id_q;
  assign retire_o      = valid_w[WB];

`ifdef KONATA_TRACKER_STATS_EN
  logic [CNT_W-1:0] retired_cnt_d, retired_cnt_q;
  logic [CNT_W-1:0] flushed_cnt_d, flushed_cnt_q;

  // Flushed count adds every valid entry removed by a kill this cycle.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    flushed_cnt_d = flushed_cnt_q + CNT_W'($countones(kill_c & valid_w));
    if (valid_w[WB]) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_q <= '0;
      flushed_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      flushed_cnt_q <= flushed_cnt_d;
    end
  end

  assign retired_cnt_o = retired_cnt_q;
  assign flushed_cnt_o = flushed_cnt_q;
`else
  assign retired_cnt_o = '0;
  assign flushed_cnt_o = '0;
`endif

endmodule

// File: tb/tb_konata_id_tracker.sv
// Directed bench for konata_id_tracker (ID_W=8 to reach the wrap point quickly).
module tb_konata_id_tracker;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned NSTG  = 6;
  localparam int unsigned CNT_W = 16;

  logic                 clk;
  logic                 rst;
  logic                 fetch_valid;
  logic [NSTG-2:0]      stall;
  logic [NSTG-2:0]      flush;
  logic [NSTG-1:0]      stage_valid;
  logic [NSTG*ID_W-1:0] stage_id;
  logic [ID_W-1:0]      next_id;
  logic                 retire;
  logic [CNT_W-1:0]     retired_cnt;
  logic [CNT_W-1:0]     flushed_cnt;

  int errors = 0;
  int checks = 0;

  konata_id_tracker #(.ID_W(ID_W), .NSTG(NSTG), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid_i(fetch_valid),
    .stall_i      (stall),
    .flush_i      (flush),
    .stage_valid_o(stage_valid),
    .stage_id_o   (stage_id),
    .next_id_o    (next_id),
    .retire_o     (retire),
    .retired_cnt_o(retired_cnt),
    .flushed_cnt_o(flushed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [NSTG-2:0] st, input logic [NSTG-2:0] fl);
    fetch_valid = fv;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ID_W-1:0] sid(input int k);
    return stage_id[k*ID_W +: ID_W];
  endfunction

  function automatic logic [CNT_W-1:0] stat_exp(input logic [CNT_W-1:0] v);
`ifdef KONATA_TRACKER_STATS_EN
    return v;
`else
    return CNT_W'(0);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    stall = '0;
    flush = '0;
    step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    check("rst_valid", 64'(stage_valid), 64'h0);
    check("rst_ids", 64'(stage_id), 64'h0);
    check("rst_next_id", 64'(next_id), 64'h0);
    check("rst_retire", 64'(retire), 64'h0);
    check("rst_retired_cnt", 64'(retired_cnt), 64'h0);
    check("rst_flushed_cnt", 64'(flushed_cnt), 64'h0);
    rst = 1'b0;

    // Three fetches: IDs 0,1,2 retire after edges 6,7,8.
    for (int i = 1; i <= 10; i++) begin
      step(i <= 3, '0, '0);
      if (i == 1) begin
        check("lat_if1_valid", 64'(stage_valid[0]), 64'h1);
        check("lat_if1_id", 64'(sid(0)), 64'h0);
        check("lat_next_id1", 64'(next_id), 64'h1);
      end
      check("lat_retire", 64'(retire), 64'((i >= 6) && (i <= 8)));
      if ((i >= 6) && (i <= 8)) check("lat_wb_id", 64'(sid(5)), 64'(i - 6));
    end
    check("lat_next_id3", 64'(next_id), 64'h3);
    check("lat_retired_cnt", 64'(retired_cnt), 64'(stat_exp(16'd3)));

    // Fill with IDs 3..8, then stall ID stage for two cycles.
    for (int i = 0; i < 6; i++) step(1'b1, '0, '0);
    check("fill_wb_id", 64'(sid(5)), 64'h3);
    check("fill_if1_id", 64'(sid(0)), 64'h8);
    check("fill_next_id", 64'(next_id), 64'h9);
    step(1'b1, 5'b00100, '0);
    check("stallA_valid", 64'(stage_valid), 64'b110111);
    check("stallA_if1", 64'(sid(0)), 64'h8);
    check("stallA_id", 64'(sid(2)), 64'h6);
    check("stallA_exe", 64'(sid(4)), 64'h5);
    check("stallA_wb", 64'(sid(5)), 64'h4);
    check("stallA_next", 64'(next_id), 64'h9);
    step(1'b1, 5'b00100, '0);
    check("stallB_valid", 64'(stage_valid), 64'b100111);
    check("stallB_wb", 64'(sid(5)), 64'h5);
    check("stallB_next", 64'(next_id), 64'h9);
    step(1'b1, '0, '0);
    check("stallC_valid", 64'(stage_valid), 64'b001111);
    check("stallC_if1", 64'(sid(0)), 64'h9);
    check("stallC_rr", 64'(sid(3)), 64'h6);
    check("stallC_next", 64'(next_id), 64'hA);
    check("stallC_retired_cnt", 64'(retired_cnt), 64'(stat_exp(16'd6)));

    // Bring IDs 10..14 into IF1..EXE, then flush from RR.
    for (int i = 0; i < 5; i++) step(1'b1, '0, '0);
    check("full_valid", 64'(stage_valid), 64'b111111);
    check("full_if1", 64'(sid(0)), 64'd14);
    check("full_rr", 64'(sid(3)), 64'd11);
    check("full_exe", 64'(sid(4)), 64'd10);
    check("full_next", 64'(next_id), 64'd15);
    step(1'b1, '0, 5'b01000);
    check("flush_valid", 64'(stage_valid), 64'b100000);
    check("flush_wb", 64'(sid(5)), 64'd10);
    check("flush_next", 64'(next_id), 64'd15);
    check("flush_flushed_cnt", 64'(flushed_cnt), 64'(stat_exp(16'd4)));
    check("flush_retired_cnt", 64'(retired_cnt), 64'(stat_exp(16'd10)));

    // Stall and flush on IF2 together: flush wins, no allocation.
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check("sf_pre_valid", 64'(stage_valid), 64'b000011);
    check("sf_pre_if2", 64'(sid(1)), 64'd15);
    step(1'b1, 5'b00010, 5'b00010);
    check("sf_valid", 64'(stage_valid), 64'h0);
    check("sf_next", 64'(next_id), 64'd17);
    check("sf_flushed_cnt", 64'(flushed_cnt), 64'(stat_exp(16'd6)));
    check("sf_retired_cnt", 64'(retired_cnt), 64'(stat_exp(16'd11)));
    step(1'b1, '0, '0);
    check("sf_resume_if1", 64'(sid(0)), 64'd17);
    check("sf_resume_next", 64'(next_id), 64'd18);

    // Walk next_id up to 255 and allocate across the wrap.
    for (int i = 0; i < 237; i++) step(1'b1, '0, '0);
    check("wrap_next_255", 64'(next_id), 64'd255);
    step(1'b1, '0, '0);
    check("wrap_if1_255", 64'(sid(0)), 64'd255);
    check("wrap_next_0", 64'(next_id), 64'd0);
    step(1'b1, '0, '0);
    check("wrap_if1_0", 64'(sid(0)), 64'd0);
    check("wrap_if2_255", 64'(sid(1)), 64'd255);
    check("wrap_next_1", 64'(next_id), 64'd1);
    check("wrap_valid", 64'(stage_valid), 64'b111111);

    // Reset with a full pipeline.
    rst = 1'b1;
    step(1'b1, '0, '0);
    check("mrst_valid", 64'(stage_valid), 64'h0);
    check("mrst_ids", 64'(stage_id), 64'h0);
    check("mrst_next", 64'(next_id), 64'h0);
    check("mrst_retired_cnt", 64'(retired_cnt), 64'h0);
    check("mrst_flushed_cnt", 64'(flushed_cnt), 64'h0);
    rst = 1'b0;
    step(1'b1, '0, '0);
    check("mrst_alloc_valid", 64'(stage_valid), 64'b000001);
    check("mrst_alloc_id", 64'(sid(0)), 64'h0);
    check("mrst_alloc_next", 64'(next_id), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
